// File: rtl/denise_bpl_serializer.sv
// ============================================================================
// denise_bpl_serializer
//
// Bitplane serializer that sits downstream of the bitplane DMA engine.
// BPLxDAT writes are captured into per-plane holding registers. A write to
// BPL1DAT arms a parallel load of all six holding registers into the shift
// registers. The shift registers are clocked out at the lowres, hires or
// shres pixel rate, pushed through a per-plane delay line, and a
// BPLCON1-selected tap gives the horizontally scrolled pixel for each plane.
//
// Ports:
//   clk            28 MHz pixel clock, the only clock domain
//   reset          asynchronous, active-high reset
//   clk7_en        one-clk pulse every 4 clk; register strobe, lowres rate
//   ecs            allows BPLCON0 to enable SHRES
//   reg_address_in register address bits [8:1]
//   data_in        register write data
//   bpldata        bit n = serialized, scrolled pixel of plane n
//   load_strobe    high for one clk after a parallel-load edge
// ============================================================================
module denise_bpl_serializer #(
    parameter int DLY_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        ecs,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [6:1]  bpldata,
    output logic        load_strobe
);

    localparam logic [8:1] ADDR_BPLCON0 = 8'h80;
    localparam logic [8:1] ADDR_BPLCON1 = 8'h81;
    localparam logic [8:1] ADDR_BPL1DAT = 8'h88;

    logic                          r_hires;
    logic                          r_shres;
    logic [2:0]                    r_bpu;
    logic [3:0]                    r_pf1h;
    logic [3:0]                    r_pf2h;
    logic [6:1][15:0]              r_holding;
    logic [6:1][15:0]              r_shift;
    logic [DLY_DEPTH-1:0][6:1]     r_dly;
    logic                          r_armed;
    logic [1:0]                    r_phase;

    logic                          w_sh_en;
    logic                          w_load;
    logic [6:1]                    w_stage0_next;
    logic [5:0]                    w_tap_odd;
    logic [5:0]                    w_tap_even;
    logic [2:0]                    w_planes;

    // Pixel-rate enable. SHRES wins over HIRES; hires pixels fall on the
    // even phase counts between clk7_en pulses.
    assign w_sh_en = r_shres ? 1'b1 : (r_hires ? ~r_phase[0] : clk7_en);

    // A load happens on the first pixel edge after BPL1DAT armed it.
    assign w_load  = w_sh_en & r_armed;

    // BPU values above 6 behave as four planes.
    assign w_planes = (r_bpu > 3'd6) ? 3'd4 : r_bpu;

    // Control register and holding register capture, clk7_en cycles only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hires   <= 1'b0;
            r_shres   <= 1'b0;
            r_bpu     <= 3'd0;
            r_pf1h    <= 4'd0;
            r_pf2h    <= 4'd0;
            r_holding <= '0;
        end else if (clk7_en) begin
            if (reg_address_in == ADDR_BPLCON0) begin
                r_hires <= data_in[15];
                r_bpu   <= data_in[14:12];
                r_shres <= data_in[6] & ecs;
            end
            if (reg_address_in == ADDR_BPLCON1) begin
                r_pf1h <= data_in[3:0];
                r_pf2h <= data_in[7:4];
            end
            for (int n = 1; n <= 6; n++) begin
                if (reg_address_in == ADDR_BPL1DAT + 8'(n - 1)) begin
                    r_holding[n] <= data_in;
                end
            end
        end
    end

    // Arm flag. A BPL1DAT write on the same edge as a pending load keeps it
    // set so the freshly written word is loaded on the following pixel edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (clk7_en && reg_address_in == ADDR_BPL1DAT) begin
            r_armed <= 1'b1;
        end else if (w_load) begin
            r_armed <= 1'b0;
        end
    end

    // Phase within the 7 MHz period, realigned by every clk7_en pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= 2'd0;
            load_strobe <= 1'b0;
        end else begin
            r_phase     <= clk7_en ? 2'd0 : r_phase + 2'd1;
            load_strobe <= w_load;
        end
    end

    // Shift registers: parallel load or shift out MSB-first, zero filling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= r_holding;
        end else if (w_sh_en) begin
            for (int n = 1; n <= 6; n++) begin
                r_shift[n] <= {r_shift[n][14:0], 1'b0};
            end
        end
    end

    // On a load edge nothing is shifted out, so stage 0 holds its pixel.
    always_comb begin
        w_stage0_next = r_dly[0];
        if (!w_load) begin
            for (int n = 1; n <= 6; n++) begin
                w_stage0_next[n] = r_shift[n][15];
            end
        end
    end

    // Delay line; element 0 is the newest pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dly <= '0;
        end else if (w_sh_en) begin
            r_dly <= {r_dly[DLY_DEPTH-2:0], w_stage0_next};
        end
    end

    // Scroll tap scales with the pixel rate so one scroll unit is always
    // one lowres pixel.
    always_comb begin
        if (r_shres) begin
            w_tap_odd  = {r_pf1h, 2'b00};
            w_tap_even = {r_pf2h, 2'b00};
        end else if (r_hires) begin
            w_tap_odd  = {1'b0, r_pf1h, 1'b0};
            w_tap_even = {1'b0, r_pf2h, 1'b0};
        end else begin
            w_tap_odd  = {2'b00, r_pf1h};
            w_tap_even = {2'b00, r_pf2h};
        end
    end

    // Tap selection and plane masking are combinational so BPLCON0/1
    // changes are visible immediately.
    always_comb begin
        bpldata = '0;
        for (int n = 1; n <= 6; n++) begin
            if (n <= int'(w_planes)) begin
                bpldata[n] = (n % 2 == 1) ? r_dly[w_tap_odd][n] : r_dly[w_tap_even][n];
            end
        end
    end

endmodule

// File: tb/tb_denise_bpl_serializer.sv
// ============================================================================
// tb_denise_bpl_serializer
//
// Bench for denise_bpl_serializer. A behavioural model keeps a log of every
// pixel emitted per plane and derives the scrolled output by looking back
// into that log; hand-written sequences cover the timing corner cases.
// ============================================================================
module tb_denise_bpl_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk7_en = 1'b0;
    logic        ecs = 1'b0;
    logic [8:1]  reg_address_in = 8'h00;
    logic [15:0] data_in = 16'h0000;
    logic [6:1]  bpldata;
    logic        load_strobe;

    int nCompared = 0;
    int nMismatched = 0;
    int phaseCnt = 0;

    typedef struct {
        logic [2:0] bpu;
        logic [6:1] expBpl;
    } maskVec_t;

    maskVec_t maskTab [0:7];

    logic [6:1] trBpl [0:127];
    logic       trLs  [0:127];

    denise_bpl_serializer #(.DLY_DEPTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .ecs            (ecs),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bpldata        (bpldata),
        .load_strobe    (load_strobe)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model state
    // ------------------------------------------------------------------
    bit          mHires = 0;
    bit          mShres = 0;
    int          mBpu = 0;
    int          mPf1h = 0;
    int          mPf2h = 0;
    logic [15:0] mHold [1:6];
    logic [15:0] mWord [1:6];
    int          mUsed = 16;
    bit          mArmed = 0;
    int          mSince = 0;
    bit          mStrobe = 0;
    logic [6:1]  mLog [$];

    // One model step per clock edge; each pixel edge appends one entry
    // to the pixel log.
    always @(posedge clk or posedge reset) begin
        bit         shEn;
        bit         doLoad;
        logic [6:1] pix;
        if (reset) begin
            mHires = 0; mShres = 0; mBpu = 0; mPf1h = 0; mPf2h = 0;
            for (int n = 1; n <= 6; n++) begin
                mHold[n] = '0;
                mWord[n] = '0;
            end
            mUsed = 16; mArmed = 0; mSince = 0; mStrobe = 0;
            mLog.delete();
        end else begin
            shEn   = mShres ? 1'b1 : (mHires ? (mSince % 2 == 0) : clk7_en);
            doLoad = shEn && mArmed;
            mStrobe = doLoad;
            pix = '0;
            if (shEn) begin
                if (doLoad) begin
                    if (mLog.size() > 0) pix = mLog[$];
                    for (int n = 1; n <= 6; n++) mWord[n] = mHold[n];
                    mUsed = 0;
                end else begin
                    for (int n = 1; n <= 6; n++) begin
                        pix[n] = (mUsed < 16) ? mWord[n][15 - mUsed] : 1'b0;
                    end
                    if (mUsed < 16) mUsed++;
                end
                mLog.push_back(pix);
            end
            if (clk7_en) begin
                if (int'(reg_address_in) == 'h80) begin
                    mHires = data_in[15];
                    mBpu   = int'(data_in[14:12]);
                    mShres = data_in[6] && ecs;
                end
                if (int'(reg_address_in) == 'h81) begin
                    mPf1h = int'(data_in[3:0]);
                    mPf2h = int'(data_in[7:4]);
                end
                for (int n = 1; n <= 6; n++) begin
                    if (int'(reg_address_in) == 'h87 + n) mHold[n] = data_in;
                end
            end
            if (clk7_en && int'(reg_address_in) == 'h88) mArmed = 1;
            else if (doLoad) mArmed = 0;
            mSince = clk7_en ? 0 : (mSince + 1) % 4;
        end
    end

    // Expected output: look back (scroll x pixel-rate multiple) entries.
    function automatic logic [6:1] modelPixels();
        logic [6:1] r;
        int planes, mult, t, idx;
        r = '0;
        planes = (mBpu > 6) ? 4 : mBpu;
        mult = mShres ? 4 : (mHires ? 2 : 1);
        for (int n = 1; n <= 6; n++) begin
            t = (((n % 2) == 1) ? mPf1h : mPf2h) * mult;
            idx = mLog.size() - 1 - t;
            if (n <= planes && idx >= 0) r[n] = mLog[idx][n];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name);
        logic [6:1] expBpl;
        expBpl = modelPixels();
        nCompared++;
        if (bpldata !== expBpl || load_strobe !== mStrobe) begin
            nMismatched++;
            $display("[TB] FAIL %s @%0t: got bpldata=%b load_strobe=%b, expected bpldata=%b load_strobe=%b",
                     name, $time, bpldata, load_strobe, expBpl, mStrobe);
        end
    endtask

    task automatic compareVal(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock, check against the model, schedule next clk7_en.
    task automatic tick();
        @(posedge clk);
        #2;
        checkOutput("model");
        phaseCnt = (phaseCnt + 1) % 4;
        clk7_en = (phaseCnt == 0);
    endtask

    // Register write on the next clk7_en edge.
    task automatic applyStimulus(input logic [8:1] addr, input logic [15:0] data);
        int guard;
        guard = 0;
        while (!clk7_en && guard < 8) begin
            tick();
            guard++;
        end
        reg_address_in = addr;
        data_in = data;
        tick();
        reg_address_in = 8'h00;
        data_in = 16'h0000;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic captureTrace(input int len);
        for (int k = 0; k < len; k++) begin
            tick();
            trBpl[k] = bpldata;
            trLs[k]  = load_strobe;
        end
    endtask

    function automatic int firstHigh(input int plane, input int len);
        for (int k = 0; k < len; k++) if (trBpl[k][plane]) return k;
        return -1;
    endfunction

    function automatic int countHigh(input int plane, input int from, input int len);
        int c;
        c = 0;
        for (int k = from; k < len; k++) if (k >= 0 && trBpl[k][plane]) c++;
        return c;
    endfunction

    function automatic int firstStrobe(input int len);
        for (int k = 0; k < len; k++) if (trLs[k]) return k;
        return -1;
    endfunction

    function automatic int countStrobe(input int len);
        int c;
        c = 0;
        for (int k = 0; k < len; k++) if (trLs[k]) c++;
        return c;
    endfunction

    // Guard against a hung run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int ls, r1, r2;
        maskTab[0] = '{3'd0, 6'b000000};
        maskTab[1] = '{3'd1, 6'b000001};
        maskTab[2] = '{3'd2, 6'b000011};
        maskTab[3] = '{3'd3, 6'b000111};
        maskTab[4] = '{3'd4, 6'b001111};
        maskTab[5] = '{3'd5, 6'b011111};
        maskTab[6] = '{3'd6, 6'b111111};
        maskTab[7] = '{3'd7, 6'b001111};

        // Reset state
        doReset();
        compareVal("reset bpldata", int'(bpldata), 0);
        compareVal("reset load_strobe", int'(load_strobe), 0);

        // Plane mask table: all six planes loaded with 0xFFFF
        for (int i = 0; i < 8; i++) begin
            doReset();
            applyStimulus(8'h80, {1'b0, maskTab[i].bpu, 12'h000});
            for (int p = 6; p >= 2; p--) applyStimulus(8'(8'h87 + p), 16'hFFFF);
            applyStimulus(8'h88, 16'hFFFF);
            repeat (12) tick();
            compareVal($sformatf("mask bpu=%0d", maskTab[i].bpu), int'(bpldata), int'(maskTab[i].expBpl));
        end

        // Lowres 0x8001, scroll 0: strobe 4 clk after write, pixels at 8 and 68
        doReset();
        applyStimulus(8'h80, 16'h1000);
        applyStimulus(8'h88, 16'h8001);
        captureTrace(80);
        for (int k = 0; k < 80; k++) begin
            int j;
            bit expBit, expLs;
            j = k + 1;
            expBit = (j >= 8 && j < 12) || (j >= 68 && j < 72);
            expLs  = (j == 4);
            compareVal($sformatf("lowres 0x8001 {strobe,pix} at T+%0d", j),
                       int'({trLs[k], trBpl[k][1]}), int'({expLs, expBit}));
        end

        // Hires, PF1H=2: 10 clk from strobe to pixel, 2 clk wide
        doReset();
        applyStimulus(8'h80, 16'h9000);
        applyStimulus(8'h81, 16'h0002);
        applyStimulus(8'h88, 16'h8000);
        captureTrace(40);
        ls = firstStrobe(40);
        r1 = firstHigh(1, 40);
        compareVal("hires strobe index", ls, 0);
        compareVal("hires delay from strobe", r1 - ls, 10);
        compareVal("hires pulse width", countHigh(1, 0, 40), 2);

        // SHRES with ecs=1, PF1H=15: tap 60, 1 clk wide
        ecs = 1'b1;
        doReset();
        applyStimulus(8'h80, 16'h1040);
        applyStimulus(8'h81, 16'h000F);
        applyStimulus(8'h88, 16'h8000);
        captureTrace(80);
        ls = firstStrobe(80);
        r1 = firstHigh(1, 80);
        compareVal("shres strobe index", ls, 0);
        compareVal("shres delay from strobe", r1 - ls, 61);
        compareVal("shres pulse width", countHigh(1, 0, 80), 1);

        // Same writes with ecs=0 fall back to lowres timing
        ecs = 1'b0;
        doReset();
        applyStimulus(8'h80, 16'h1040);
        applyStimulus(8'h81, 16'h000F);
        applyStimulus(8'h88, 16'h8000);
        captureTrace(90);
        ls = firstStrobe(90);
        r1 = firstHigh(1, 90);
        compareVal("no-ecs strobe index", ls, 3);
        compareVal("no-ecs delay from strobe", r1 - ls, 64);
        compareVal("no-ecs pulse width", countHigh(1, 0, 90), 4);

        // Lowres BPU=2, PF2H=3: plane 2 lags plane 1 by 12 clk
        doReset();
        applyStimulus(8'h80, 16'h2000);
        applyStimulus(8'h81, 16'h0030);
        applyStimulus(8'h89, 16'hFFFF);
        applyStimulus(8'h88, 16'hFFFF);
        captureTrace(100);
        r1 = firstHigh(1, 100);
        r2 = firstHigh(2, 100);
        compareVal("scroll plane1 rise", r1, 7);
        compareVal("scroll plane2 lag", r2 - r1, 12);
        compareVal("scroll plane2 width", countHigh(2, 0, 100), 64);
        compareVal("scroll plane1 width", countHigh(1, 0, 100), 64);

        // Reload with 0x0000 after 8 shifts discards the rest of 0xFFFF
        doReset();
        applyStimulus(8'h80, 16'h1000);
        applyStimulus(8'h88, 16'hFFFF);
        repeat (36) tick();
        compareVal("before reload pixel", int'(bpldata[1]), 1);
        applyStimulus(8'h88, 16'h0000);
        captureTrace(80);
        ls = firstStrobe(80);
        compareVal("reload strobe index", ls, 3);
        compareVal("reload ones after load", countHigh(1, ls + 4, 80), 0);

        // Asynchronous reset mid-word
        applyStimulus(8'h88, 16'hFFFF);
        repeat (20) tick();
        compareVal("pre-reset pixel", int'(bpldata[1]), 1);
        #3;
        reset = 1'b1;
        #1;
        compareVal("async reset bpldata", int'(bpldata), 0);
        compareVal("async reset load_strobe", int'(load_strobe), 0);
        checkOutput("async reset");
        tick();
        tick();
        reset = 1'b0;
        captureTrace(60);
        compareVal("post-reset strobes", countStrobe(60), 0);
        compareVal("post-reset plane1 ones", countHigh(1, 0, 60), 0);

        // Randomized register traffic against the model
        doReset();
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                ecs = 1'($urandom_range(0, 1));
                applyStimulus(8'h80, 16'($urandom));
            end else if (kind == 1) begin
                applyStimulus(8'h81, 16'($urandom));
            end else if (kind <= 4) begin
                applyStimulus(8'(8'h87 + $urandom_range(2, 6)), 16'($urandom));
            end else begin
                applyStimulus(8'h88, 16'($urandom));
            end
            repeat ($urandom_range(0, 40)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
